mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 244 ++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Two-requester arbiter and sequencer for the single synchronous memory port.
// Port 0 is the control state machine's MAR/MDR path, port 1 is the DMA /
// program loader. A winning request is latched in IDLE, then driven to memory
// for MEM_LAT cycles (ACCESS), read data is captured on the final ACCESS edge
// and a one-cycle acknowledge is returned to the owner (DONE).
//
// Parameters
//   ADDR_W   address width
//   DATA_W   data width
//   MEM_LAT  memory access cycles with mem_en held high (1..15)
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   req0/req1          access request, port 0 (CPU) / port 1 (DMA)
//   we0/we1            1 = write, 0 = read
//   addr0/addr1        access address
//   wdata0/wdata1      write data
//   ack0/ack1          one-cycle completion pulse (registered)
//   rdata              registered read data, valid with the matching ack
//   busy               high while in ACCESS or DONE (registered)
//   mem_en, mem_we     memory strobe / write enable (registered)
//   mem_addr           memory address (registered)
//   mem_wdata          memory write data (registered)
//   mem_rdata          memory read data, valid in the last ACCESS cycle
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Wait counter is preloaded with MEM_LAT-1 so that ACCESS lasts MEM_LAT
  // cycles; MEM_LAT=1 loads zero and ACCESS lasts a single cycle.
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  // Registered state
  state_t            state_r;
  logic [3:0]        cnt_r;
  logic              owner_r;
  logic              last_gnt_r;
  logic              ack0_r;
  logic              ack1_r;
  logic [DATA_W-1:0] rdata_r;
  logic              busy_r;
  logic              mem_en_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;

  // Next-state values
  state_t            state_s;
  logic [3:0]        cnt_s;
  logic              owner_s;
  logic              last_gnt_s;
  logic              ack0_s;
  logic              ack1_s;
  logic [DATA_W-1:0] rdata_s;
  logic              busy_s;
  logic              mem_en_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  // Arbitration result
  logic              gnt_valid_s;
  logic              gnt_port_s;
  logic              gnt_we_s;
  logic [ADDR_W-1:0] gnt_addr_s;
  logic [DATA_W-1:0] gnt_wdata_s;

  // Round-robin arbitration: on a tie the port that did not win last time
  // wins now, so a pending port 1 always follows a port-0 grant.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_port_s  = 1'b0;
    if (req0 && req1) begin
      gnt_valid_s = 1'b1;
      gnt_port_s  = ~last_gnt_r;
    end else if (req0) begin
      gnt_valid_s = 1'b1;
      gnt_port_s  = 1'b0;
    end else if (req1) begin
      gnt_valid_s = 1'b1;
      gnt_port_s  = 1'b1;
    end else begin
      gnt_valid_s = 1'b0;
      gnt_port_s  = 1'b0;
    end
  end

  // Winner's access attributes, muxed by the grant decision.
  always_comb begin
    if (gnt_port_s) begin
      gnt_we_s    = we1;
      gnt_addr_s  = addr1;
      gnt_wdata_s = wdata1;
    end else begin
      gnt_we_s    = we0;
      gnt_addr_s  = addr0;
      gnt_wdata_s = wdata0;
    end
  end

  // Next-state and next-output logic; every output is computed here one
  // cycle ahead and registered below.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    owner_s     = owner_r;
    last_gnt_s  = last_gnt_r;
    ack0_s      = 1'b0;
    ack1_s      = 1'b0;
    rdata_s     = rdata_r;
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;

    case (state_r)
      ST_IDLE: begin
        if (gnt_valid_s) begin
          state_s     = ST_ACCESS;
          cnt_s       = CNT_LOAD;
          owner_s     = gnt_port_s;
          last_gnt_s  = gnt_port_s;
          mem_en_s    = 1'b1;
          mem_we_s    = gnt_we_s;
          mem_addr_s  = gnt_addr_s;
          mem_wdata_s = gnt_wdata_s;
        end else begin
          state_s  = ST_IDLE;
          mem_en_s = 1'b0;
          mem_we_s = 1'b0;
        end
      end

      ST_ACCESS: begin
        if (cnt_r == 4'd0) begin
          // Final access cycle: mem_rdata is valid now. Writes leave rdata
          // untouched so the requester never sees stale write-cycle data.
          state_s  = ST_DONE;
          mem_en_s = 1'b0;
          mem_we_s = 1'b0;
          if (!mem_we_r) begin
            rdata_s = mem_rdata;
          end else begin
            rdata_s = rdata_r;
          end
          if (owner_r) begin
            ack1_s = 1'b1;
          end else begin
            ack0_s = 1'b1;
          end
        end else begin
          state_s  = ST_ACCESS;
          cnt_s    = cnt_r - 4'd1;
          mem_en_s = 1'b1;
          mem_we_s = mem_we_r;
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      owner_r     <= 1'b0;
      last_gnt_r  <= 1'b1;
      ack0_r      <= 1'b0;
      ack1_r      <= 1'b0;
      rdata_r     <= {DATA_W{1'b0}};
      busy_r      <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      owner_r     <= owner_s;
      last_gnt_r  <= last_gnt_s;
      ack0_r      <= ack0_s;
      ack1_r      <= ack1_s;
      rdata_r     <= rdata_s;
      busy_r      <= busy_s;
      mem_en_r    <= mem_en_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
    end
  end

  assign ack0      = ack0_r;
  assign ack1      = ack1_r;
  assign rdata     = rdata_r;
  assign busy      = busy_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Two instances: MEM_LAT=2 (dut) and
// MEM_LAT=1 (dut1). Inputs change and outputs are checked on the falling
// edge. A memory model returns 0xBEEF at 0x3000 and addr^0x5A5A elsewhere.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  int          n_cmp;
  int          n_err;

  // MEM_LAT=2 instance signals
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, busy, mem_en, mem_we;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;

  // MEM_LAT=1 instance signals
  logic        p_req0, p_req1, p_we0, p_we1;
  logic [15:0] p_addr0, p_addr1, p_wdata0, p_wdata1;
  logic        p_ack0, p_ack1, p_busy, p_mem_en, p_mem_we;
  logic [15:0] p_rdata, p_mem_addr, p_mem_wdata, p_mem_rdata;

  assign mem_rdata   = (mem_addr   == 16'h3000) ? 16'hBEEF : (mem_addr   ^ 16'h5A5A);
  assign p_mem_rdata = (p_mem_addr == 16'h3000) ? 16'hBEEF : (p_mem_addr ^ 16'h5A5A);

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .req0(p_req0), .req1(p_req1), .we0(p_we0), .we1(p_we1),
    .addr0(p_addr0), .addr1(p_addr1), .wdata0(p_wdata0), .wdata1(p_wdata1),
    .ack0(p_ack0), .ack1(p_ack1), .rdata(p_rdata), .busy(p_busy),
    .mem_en(p_mem_en), .mem_we(p_mem_we), .mem_addr(p_mem_addr),
    .mem_wdata(p_mem_wdata), .mem_rdata(p_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({ack0, ack1, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata} !== 53'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got ack=%b%b rdata=%h busy=%b en=%b we=%b addr=%h wdata=%h, need all zero",
               ack0, ack1, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata);
    end
    n_cmp++;
    if ({p_ack0, p_ack1, p_rdata, p_busy, p_mem_en, p_mem_we, p_mem_addr, p_mem_wdata} !== 53'd0) begin
      n_err++;
      $display("FAIL reset_outputs_lat1: got ack=%b%b rdata=%h busy=%b en=%b, need all zero",
               p_ack0, p_ack1, p_rdata, p_busy, p_mem_en);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h3000;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({mem_en, mem_we, busy, ack0, ack1, mem_addr} !== {5'b10100, 16'h3000}) begin
        n_err++;
        $display("FAIL read_access_c%0d: got en=%b we=%b busy=%b ack=%b%b addr=%h, need en=1 we=0 busy=1 ack=00 addr=3000",
                 c, mem_en, mem_we, busy, ack0, ack1, mem_addr);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({ack0, ack1, mem_en, busy} !== 4'b1001) begin
      n_err++;
      $display("FAIL read_ack: got ack0=%b ack1=%b en=%b busy=%b, need 1 0 0 1", ack0, ack1, mem_en, busy);
    end
    n_cmp++;
    if (rdata !== 16'hBEEF) begin
      n_err++;
      $display("FAIL read_rdata: got %h need beef", rdata);
    end
    req0 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ack0, ack1, busy, mem_en} !== 4'b0000) begin
      n_err++;
      $display("FAIL read_after: got ack=%b%b busy=%b en=%b need 0000", ack0, ack1, busy, mem_en);
    end
  endtask

  task automatic test_single_write();
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0042; wdata1 = 16'h1234;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'h0042, 16'h1234}) begin
        n_err++;
        $display("FAIL write_access_c%0d: got en=%b we=%b addr=%h wdata=%h, need 1 1 0042 1234",
                 c, mem_en, mem_we, mem_addr, mem_wdata);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({ack1, ack0, mem_en, mem_we} !== 4'b1000) begin
      n_err++;
      $display("FAIL write_ack: got ack1=%b ack0=%b en=%b we=%b need 1 0 0 0", ack1, ack0, mem_en, mem_we);
    end
    n_cmp++;
    if (rdata !== 16'hBEEF) begin
      n_err++;
      $display("FAIL write_rdata_kept: got %h need beef", rdata);
    end
    req1 = 1'b0; we1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    int ack_cyc[8];
    int ack_port[8];
    logic [15:0] ack_data[8];
    int n_ack;
    int coincide;
    n_ack = 0;
    coincide = 0;
    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0100;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0200;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (ack0 && ack1) coincide++;
      if ((ack0 || ack1) && n_ack < 8) begin
        ack_cyc[n_ack]  = c;
        ack_port[n_ack] = ack1 ? 1 : 0;
        ack_data[n_ack] = rdata;
        n_ack++;
      end
      if (c == 15) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    n_cmp++;
    if (n_ack != 4) begin
      n_err++;
      $display("FAIL contention_count: got %0d acks need 4", n_ack);
    end
    n_cmp++;
    if (coincide != 0) begin
      n_err++;
      $display("FAIL contention_coincident: got %0d cycles with both acks need 0", coincide);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < n_ack) begin
        n_cmp++;
        if (ack_port[i] != (i % 2) || ack_cyc[i] != 3 + 4 * i) begin
          n_err++;
          $display("FAIL contention_ack%0d: got port %0d at cycle %0d need port %0d at cycle %0d",
                   i, ack_port[i], ack_cyc[i], i % 2, 3 + 4 * i);
        end
        n_cmp++;
        if (ack_data[i] !== ((i % 2 == 0) ? 16'h5B5A : 16'h585A)) begin
          n_err++;
          $display("FAIL contention_rdata%0d: got %h need %h", i, ack_data[i],
                   (i % 2 == 0) ? 16'h5B5A : 16'h585A);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_late_arrival();
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0300;
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0400;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({ack0, ack1} !== 2'b10) begin
      n_err++;
      $display("FAIL late_first_ack: got ack0=%b ack1=%b need 1 0", ack0, ack1);
    end
    req0 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, mem_en, ack0, ack1} !== 4'b0000) begin
      n_err++;
      $display("FAIL late_idle: got busy=%b en=%b ack=%b%b need 0000", busy, mem_en, ack0, ack1);
    end
    @(negedge clk);
    n_cmp++;
    if ({mem_en, mem_addr} !== {1'b1, 16'h0400}) begin
      n_err++;
      $display("FAIL late_grant1: got en=%b addr=%h need 1 0400", mem_en, mem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({ack1, ack0, rdata} !== {2'b10, 16'h5E5A}) begin
      n_err++;
      $display("FAIL late_second_ack: got ack1=%b ack0=%b rdata=%h need 1 0 5e5a", ack1, ack0, rdata);
    end
    req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    // last_gnt is 0 after the preceding port-0 grant; reset must bring it back to 1.
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0500;
    @(negedge clk);
    n_cmp++;
    if (mem_en !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_in_access: got en=%b need 1", mem_en);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({mem_en, busy, ack0, ack1, mem_addr} !== {4'b0000, 16'h0000}) begin
      n_err++;
      $display("FAIL midrst_abandon: got en=%b busy=%b ack=%b%b addr=%h need 0 0 00 0000",
               mem_en, busy, ack0, ack1, mem_addr);
    end
    reset = 1'b0;
    req0 = 1'b1; addr0 = 16'h0600;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0700;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++;
        if ({mem_en, mem_addr} !== {1'b1, 16'h0600}) begin
          n_err++;
          $display("FAIL midrst_first_grant: got en=%b addr=%h need 1 0600", mem_en, mem_addr);
        end
      end
      if (c == 2) begin
        n_cmp++;
        if ({ack0, ack1} !== 2'b00) begin
          n_err++;
          $display("FAIL midrst_no_early_ack: got ack=%b%b need 00", ack0, ack1);
        end
      end
    end
    n_cmp++;
    if ({ack0, ack1} !== 2'b10) begin
      n_err++;
      $display("FAIL midrst_ack0: got ack0=%b ack1=%b need 1 0", ack0, ack1);
    end
    req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({mem_en, mem_addr} !== {1'b1, 16'h0700}) begin
      n_err++;
      $display("FAIL midrst_second_grant: got en=%b addr=%h need 1 0700", mem_en, mem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({ack1, rdata} !== {1'b1, 16'h5D5A}) begin
      n_err++;
      $display("FAIL midrst_ack1: got ack1=%b rdata=%h need 1 5d5a", ack1, rdata);
    end
    req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lat1_read();
    p_req0 = 1'b1; p_we0 = 1'b0; p_addr0 = 16'h3000;
    @(negedge clk);
    n_cmp++;
    if ({p_mem_en, p_mem_addr, p_ack0} !== {1'b1, 16'h3000, 1'b0}) begin
      n_err++;
      $display("FAIL lat1_access: got en=%b addr=%h ack0=%b need 1 3000 0", p_mem_en, p_mem_addr, p_ack0);
    end
    @(negedge clk);
    n_cmp++;
    if ({p_ack0, p_ack1, p_mem_en, p_rdata} !== {3'b100, 16'hBEEF}) begin
      n_err++;
      $display("FAIL lat1_ack: got ack0=%b ack1=%b en=%b rdata=%h need 1 0 0 beef",
               p_ack0, p_ack1, p_mem_en, p_rdata);
    end
    p_req0 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({p_ack0, p_busy} !== 2'b00) begin
      n_err++;
      $display("FAIL lat1_after: got ack0=%b busy=%b need 0 0", p_ack0, p_busy);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 16'h0000; addr1 = 16'h0000; wdata0 = 16'h0000; wdata1 = 16'h0000;
    p_req0 = 1'b0; p_req1 = 1'b0; p_we0 = 1'b0; p_we1 = 1'b0;
    p_addr0 = 16'h0000; p_addr1 = 16'h0000; p_wdata0 = 16'h0000; p_wdata1 = 16'h0000;

    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_late_arrival();
    test_reset_mid_access();
    test_lat1_read();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
